// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin arbiter sharing one AXI3 read port between two requesters
module axi_rd_arbiter #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 64,
  parameter int id_width_p   = 6,
  parameter int len_width_p  = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [id_width_p-1:0]   s0_axi_arid,
  input  logic [addr_width_p-1:0] s0_axi_araddr,
  input  logic [len_width_p-1:0]  s0_axi_arlen,
  input  logic [2:0]              s0_axi_arsize,
  input  logic [1:0]              s0_axi_arburst,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [id_width_p-1:0]   s0_axi_rid,
  output logic [data_width_p-1:0] s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  output logic                    s0_axi_rlast,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  input  logic [id_width_p-1:0]   s1_axi_arid,
  input  logic [addr_width_p-1:0] s1_axi_araddr,
  input  logic [len_width_p-1:0]  s1_axi_arlen,
  input  logic [2:0]              s1_axi_arsize,
  input  logic [1:0]              s1_axi_arburst,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [id_width_p-1:0]   s1_axi_rid,
  output logic [data_width_p-1:0] s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rlast,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  output logic [id_width_p-1:0]   m_axi_arid,
  output logic [addr_width_p-1:0] m_axi_araddr,
  output logic [len_width_p-1:0]  m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [id_width_p-1:0]   m_axi_rid,
  input  logic [data_width_p-1:0] m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    grant_o,
  output logic                    busy_o,
  output logic                    err_o
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  localparam logic [len_width_p:0] one_c = 1;
  state_e                 r_state;
  logic                   r_grant;
  logic                   r_last;
  logic                   r_err;
  logic [len_width_p-1:0] r_len;
  logic [len_width_p:0]   r_beats;
  logic                   w_pick;
  logic                   w_ar_hs;
  logic                   w_r_hs;
  logic                   w_len_hit;
  logic [len_width_p:0]   w_beats_nx;
  // On a tie the requester that did not win last time is chosen
  assign w_pick     = (s0_axi_arvalid && s1_axi_arvalid) ? ~r_last : s1_axi_arvalid;
  assign m_axi_arid    = r_grant ? s1_axi_arid    : s0_axi_arid;
  assign m_axi_araddr  = r_grant ? s1_axi_araddr  : s0_axi_araddr;
  assign m_axi_arlen   = r_grant ? s1_axi_arlen   : s0_axi_arlen;
  assign m_axi_arsize  = r_grant ? s1_axi_arsize  : s0_axi_arsize;
  assign m_axi_arburst = r_grant ? s1_axi_arburst : s0_axi_arburst;
  assign m_axi_arvalid = (r_state == ADDR) && (r_grant ? s1_axi_arvalid : s0_axi_arvalid);
  assign s0_axi_arready = (r_state == ADDR) && !r_grant && m_axi_arready;
  assign s1_axi_arready = (r_state == ADDR) &&  r_grant && m_axi_arready;
  assign m_axi_rready  = (r_state == DATA) && (r_grant ? s1_axi_rready : s0_axi_rready);
  assign s0_axi_rvalid = (r_state == DATA) && !r_grant && m_axi_rvalid;
  assign s1_axi_rvalid = (r_state == DATA) &&  r_grant && m_axi_rvalid;
  assign s0_axi_rid   = m_axi_rid;
  assign s0_axi_rdata = m_axi_rdata;
  assign s0_axi_rresp = m_axi_rresp;
  assign s0_axi_rlast = m_axi_rlast;
  assign s1_axi_rid   = m_axi_rid;
  assign s1_axi_rdata = m_axi_rdata;
  assign s1_axi_rresp = m_axi_rresp;
  assign s1_axi_rlast = m_axi_rlast;
  assign w_ar_hs    = m_axi_arvalid && m_axi_arready;
  assign w_r_hs     = m_axi_rvalid && m_axi_rready;
  assign w_beats_nx = r_beats + one_c;
  assign w_len_hit  = w_beats_nx == ({1'b0, r_len} + one_c);
  assign grant_o = r_grant;
  assign busy_o  = r_state != IDLE;
  assign err_o   = r_err;
  // Grant/address/data sequencing; a beat is in error when rlast and the expected count disagree
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_len   <= '0;
      r_beats <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (s0_axi_arvalid || s1_axi_arvalid) begin
          r_grant <= w_pick;
          r_len   <= w_pick ? s1_axi_arlen : s0_axi_arlen;
          r_beats <= '0;
          r_state <= ADDR;
        end
        ADDR: if (w_ar_hs) begin
          r_last  <= r_grant;
          r_state <= DATA;
        end
        DATA: if (w_r_hs) begin
          r_beats <= w_beats_nx;
          if (m_axi_rlast) r_state <= IDLE;
          if (m_axi_rlast != w_len_hit) r_err <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
